// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
//   Instruction-fetch stage that sits after the next-PC mux. It holds the PC,
//   fetches one instruction at a time from imem over a req/ready handshake,
//   and presents it to decode over a valid/ready handshake. An execute-stage
//   redirect replaces the PC and flushes any fetch that is still in flight.
//
// Parameters
//   WIDTH      PC / address / instruction width
//   RESET_PC   PC value loaded on reset
//   STEP       sequential PC increment
//   ALIGN_BITS number of low bits of i_redirect_pc forced to zero
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        asynchronous, active-high reset
//   i_redirect     load redirect target into the PC and flush the current fetch
//   i_redirect_pc  redirect target from EX
//   o_imem_req     fetch request, held until i_imem_ready
//   o_imem_addr    fetch address, stable while o_imem_req is high
//   i_imem_ready   i_imem_rdata valid; completes the imem transaction
//   i_imem_rdata   fetched instruction
//   o_ins_valid    o_ins / o_ins_pc valid to decode
//   i_ins_ready    decode accepts o_ins this cycle
//   o_ins          instruction
//   o_ins_pc       address of o_ins
//   o_perf_fetched instructions handed to decode (FETCH_PERF_EN only)
//   o_perf_flushed fetched instructions thrown away (FETCH_PERF_EN only)
//
// Configuration
//   FETCH_PERF_EN  when defined, adds saturating 16-bit fetch/flush counters.
// -----------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               STEP       = 4,
    parameter int               ALIGN_BITS = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_ready,
    input  logic [WIDTH-1:0] i_imem_rdata,
    output logic             o_ins_valid,
    input  logic             i_ins_ready,
    output logic [WIDTH-1:0] o_ins,
    output logic [WIDTH-1:0] o_ins_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]      o_perf_fetched,
    output logic [15:0]      o_perf_flushed
`endif
);

    // state | meaning
    // IDLE  | out of reset, PC loaded, no request yet
    // REQ   | imem request outstanding at r_imem_addr
    // HOLD  | instruction presented to decode, waiting for i_ins_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

    state_t           r_state,      w_state_nxt;
    logic [WIDTH-1:0] r_pc,         w_pc_nxt;
    logic [WIDTH-1:0] r_imem_addr,  w_imem_addr_nxt;
    logic [WIDTH-1:0] r_ins,        w_ins_nxt;
    logic [WIDTH-1:0] r_ins_pc,     w_ins_pc_nxt;
    logic             r_ins_valid,  w_ins_valid_nxt;
    logic             r_flush_pend, w_flush_pend_nxt;

    logic [WIDTH-1:0] w_target;
    logic             w_complete;

    assign w_target   = i_redirect_pc & ALIGN_MASK;
    assign w_complete = (r_state == ST_REQ) && i_imem_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_imem_addr  <= '0;
            r_ins        <= '0;
            r_ins_pc     <= '0;
            r_ins_valid  <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_ins        <= w_ins_nxt;
            r_ins_pc     <= w_ins_pc_nxt;
            r_ins_valid  <= w_ins_valid_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    // Every transition into REQ latches the *updated* PC as the fetch address,
    // so a redirect taken on the same edge is fetched immediately.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_imem_addr_nxt  = r_imem_addr;
        w_ins_nxt        = r_ins;
        w_ins_pc_nxt     = r_ins_pc;
        w_ins_valid_nxt  = r_ins_valid;
        w_flush_pend_nxt = r_flush_pend;

        case (r_state)
            ST_IDLE: begin
                if (i_redirect) begin
                    w_pc_nxt = w_target;
                end
                w_imem_addr_nxt = w_pc_nxt;
                w_state_nxt     = ST_REQ;
            end
            ST_REQ: begin
                if (!i_imem_ready) begin
                    // Request must stay stable; remember the flush for later.
                    if (i_redirect) begin
                        w_pc_nxt         = w_target;
                        w_flush_pend_nxt = 1'b1;
                    end
                end else if (r_flush_pend || i_redirect) begin
                    w_flush_pend_nxt = 1'b0;
                    if (i_redirect) begin
                        w_pc_nxt = w_target;
                    end
                    w_imem_addr_nxt = w_pc_nxt;
                    w_state_nxt     = ST_REQ;
                end else begin
                    w_ins_nxt       = i_imem_rdata;
                    w_ins_pc_nxt    = r_imem_addr;
                    w_ins_valid_nxt = 1'b1;
                    w_pc_nxt        = r_imem_addr + WIDTH'(STEP);
                    w_state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_redirect) begin
                    w_ins_valid_nxt = 1'b0;
                    w_pc_nxt        = w_target;
                    w_imem_addr_nxt = w_target;
                    w_state_nxt     = ST_REQ;
                end else if (i_ins_ready) begin
                    w_ins_valid_nxt = 1'b0;
                    w_imem_addr_nxt = r_pc;
                    w_state_nxt     = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_imem_req  = (r_state == ST_REQ);
    assign o_imem_addr = r_imem_addr;
    assign o_ins_valid = r_ins_valid;
    assign o_ins       = r_ins;
    assign o_ins_pc    = r_ins_pc;

`ifdef FETCH_PERF_EN
    logic        w_perf_fetch_inc;
    logic        w_perf_flush_inc;
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_flushed;

    assign w_perf_fetch_inc = r_ins_valid && i_ins_ready && !i_redirect;
    assign w_perf_flush_inc = (w_complete && (r_flush_pend || i_redirect)) ||
                              ((r_state == ST_HOLD) && r_ins_valid && i_redirect);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_perf_fetch_inc && (r_perf_fetched != 16'hFFFF)) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if (w_perf_flush_inc && (r_perf_flushed != 16'hFFFF)) begin
                r_perf_flushed <= r_perf_flushed + 16'd1;
            end
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_flushed = r_perf_flushed;
`endif

endmodule
